// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encoding, default sizes
// and the 2-bit saturating counter update.
package branch_predictor_pkg;

  localparam int unsigned DEF_ENTRIES = 64;
  localparam int unsigned DEF_TAG_W   = 10;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != ST)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != SNT)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped valid/tag/target/counter storage: combinational lookup read,
// combinational EX-side read for training, one synchronous write port.
module branch_predictor_btb_array
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [63:0]      lk_target,
  output logic [1:0]       lk_ctr,
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_rd_valid,
  output logic [TAG_W-1:0] ex_rd_tag,
  output logic [63:0]      ex_rd_target,
  output logic [1:0]       ex_rd_ctr,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_target,
  input  logic [1:0]       wr_ctr
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [63:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  assign lk_valid     = valid_q[lk_idx];
  assign lk_tag       = tag_q[lk_idx];
  assign lk_target    = target_q[lk_idx];
  assign lk_ctr       = ctr_q[lk_idx];
  assign ex_rd_valid  = valid_q[ex_idx];
  assign ex_rd_tag    = tag_q[ex_idx];
  assign ex_rd_target = target_q[ex_idx];
  assign ex_rd_ctr    = ctr_q[ex_idx];

  // Writes always land on the EX-side index; an allocate or a hit both mark the entry valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= wr_tag;
      target_q[ex_idx] <= wr_target;
      ctr_q[ex_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: combinational IF lookup, combinational EX
// misprediction resolution, training on resolved branches, statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned TAG_W   = DEF_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_pred,
  input  logic [63:0] ex_pred_target,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  output logic        mispredict,
  output logic [63:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + 2 + TAG_W - 1;

  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0] lk_pc_tag, ex_pc_tag;
  logic             lk_valid, ex_rd_valid;
  logic [TAG_W-1:0] lk_tag, ex_rd_tag;
  logic [63:0]      lk_target, ex_rd_target;
  logic [1:0]       lk_ctr, ex_rd_ctr;
  logic             lk_hit, ex_hit;
  logic             wr_en;
  logic [63:0]      wr_target;
  logic [1:0]       wr_ctr;
  logic             unused_pc_bits;

  assign lk_idx    = if_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign lk_pc_tag = if_pc[TAG_HI:TAG_LO];
  assign ex_pc_tag = ex_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{if_pc[63:TAG_HI+1], if_pc[1:0], ex_pc[63:TAG_HI+1], ex_pc[1:0],
                            lk_ctr[0]};

  branch_predictor_btb_array #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lk_idx       (lk_idx),
    .lk_valid     (lk_valid),
    .lk_tag       (lk_tag),
    .lk_target    (lk_target),
    .lk_ctr       (lk_ctr),
    .ex_idx       (ex_idx),
    .ex_rd_valid  (ex_rd_valid),
    .ex_rd_tag    (ex_rd_tag),
    .ex_rd_target (ex_rd_target),
    .ex_rd_ctr    (ex_rd_ctr),
    .wr_en        (wr_en),
    .wr_tag       (ex_pc_tag),
    .wr_target    (wr_target),
    .wr_ctr       (wr_ctr)
  );

  // Lookup reads pre-update storage, so a same-cycle update becomes visible next cycle.
  assign lk_hit      = lk_valid && (lk_tag == lk_pc_tag);
  assign pred_taken  = lk_hit && lk_ctr[1];
  assign pred_target = lk_hit ? lk_target : if_pc + 64'd4;

  assign mispredict  = ex_valid && ((ex_pred != ex_taken) ||
                                    (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = (mispredict && ex_taken) ? ex_target : ex_pc + 64'd4;
  assign flush_if_id = mispredict;
  assign flush_id_ex = mispredict;

  // Not-taken misses leave the table alone; taken misses replace whatever aliases there.
  assign ex_hit    = ex_rd_valid && (ex_rd_tag == ex_pc_tag);
  assign wr_en     = ex_valid && (ex_hit || ex_taken);
  assign wr_target = ex_taken ? ex_target : ex_rd_target;
  assign wr_ctr    = ex_hit ? sat_ctr_next(ex_rd_ctr, ex_taken) : WT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_valid)
        branch_cnt <= branch_cnt + 32'd1;
      if (mispredict)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule
